// File: rtl/l2_cache_pkg.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_pkg
// Purpose  : Shared geometry, address field ranges and FSM encodings for the
//            8-way, 64-set, 64-byte-line L2 cache.
// Revision : 1.0 - initial release
// ============================================================================
package l2_cache_pkg;

   localparam int L2_LINE_WIDTH = 512;
   localparam int L2_WAYS       = 8;
   localparam int L2_SETS       = 64;
   localparam int ADDR_WIDTH    = 32;

   localparam int WAY_W = 3;
   localparam int SET_W = 6;
   localparam int AGE_W = 3;
   localparam int TAG_W = 20;
   localparam int ENT_W = SET_W + WAY_W;

   // Byte-address field boundaries
   localparam int OFF_LO = 0;
   localparam int OFF_HI = 5;
   localparam int IDX_LO = 6;
   localparam int IDX_HI = 11;
   localparam int TAG_LO = 12;
   localparam int TAG_HI = 31;

   typedef logic [2:0] state_t;
   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_LOOKUP    = 3'd1;
   localparam state_t S_WRITEBACK = 3'd2;
   localparam state_t S_FETCH     = 3'd3;
   localparam state_t S_RESPOND   = 3'd4;

   // Line-aligned byte address rebuilt from a tag and a set index
   function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                       input logic [SET_W-1:0] idx);
      return {tag, idx, 6'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/l2_cache_lru.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache_lru
// Purpose  : True-LRU age array, one 3-bit age per way per set. Ages always
//            form a permutation of 0..7; the oldest way (age 7) is the victim.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache_lru
   import l2_cache_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [SET_W-1:0] i_set,
   input  logic             i_touch_en,
   input  logic [WAY_W-1:0] i_touch_way,
   output logic [WAY_W-1:0] o_victim_way
);

   logic [AGE_W-1:0] r_age [L2_SETS][L2_WAYS];
   logic [AGE_W-1:0] w_old_age;

   assign w_old_age = r_age[i_set][i_touch_way];

   // Age update: touched way becomes youngest, ways younger than it age by one
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int s = 0; s < L2_SETS; s++) begin
            for (int w = 0; w < L2_WAYS; w++) begin
               r_age[s][w] <= AGE_W'(w);
            end
         end
      end else if (i_touch_en) begin
         for (int w = 0; w < L2_WAYS; w++) begin
            if (WAY_W'(w) == i_touch_way) begin
               r_age[i_set][w] <= '0;
            end else if (r_age[i_set][w] < w_old_age) begin
               r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
            end
         end
      end
   end

   // Victim is the unique way holding the maximum age in the selected set
   always_comb begin
      o_victim_way = '0;
      for (int w = 0; w < L2_WAYS; w++) begin
         if (r_age[i_set][w] == AGE_W'(L2_WAYS - 1)) begin
            o_victim_way = WAY_W'(w);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/l2_cache.sv
`default_nettype none
// ============================================================================
// Module   : l2_cache
// Purpose  : 32 KiB unified write-back / write-allocate L2 cache, 8 ways x
//            64 sets x 512-bit lines, whole-line L1 and memory transfers.
// Revision : 1.0 - initial release
// ============================================================================
module l2_cache
   import l2_cache_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [ADDR_WIDTH-1:0]    l1_addr,
   input  logic [L2_LINE_WIDTH-1:0] l1_wdata,
   input  logic                     l1_rd,
   input  logic                     l1_wr,
   output logic [L2_LINE_WIDTH-1:0] l1_rdata,
   output logic                     l1_ready,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [L2_LINE_WIDTH-1:0] mem_wdata,
   output logic                     mem_rd,
   output logic                     mem_wr,
   input  logic [L2_LINE_WIDTH-1:0] mem_rdata,
   input  logic                     mem_ready
);

   localparam int ENTRIES = L2_SETS * L2_WAYS;

   state_t r_state, w_next_state;

   // Latched request; byte offset is irrelevant for whole-line transfers
   logic [ADDR_WIDTH-1:IDX_LO] r_addr;
   logic [L2_LINE_WIDTH-1:0]   r_wdata;
   logic                       r_is_wr;
   logic [WAY_W-1:0]           r_victim;

   // Storage, flat-indexed by {set, way}
   logic [L2_LINE_WIDTH-1:0] r_data [ENTRIES];
   logic [TAG_W-1:0]         r_tag  [ENTRIES];
   logic [ENTRIES-1:0]       r_valid, r_dirty;

   logic [SET_W-1:0]         w_set;
   logic [TAG_W-1:0]         w_tag;
   logic                     w_hit, w_inv_found, w_victim_dirty;
   logic [WAY_W-1:0]         w_hit_way, w_inv_way, w_lru_victim, w_victim_new, w_cur_victim;
   logic                     w_lookup_hit, w_hit_wr, w_wb_done, w_fill, w_install_wr;
   logic                     w_arr_we, w_touch_en;
   logic [WAY_W-1:0]         w_touch_way;
   logic [ENT_W-1:0]         w_arr_ent;
   logic [L2_LINE_WIDTH-1:0] w_arr_line;
   logic                     w_l1_ready_nxt, w_mem_rd_nxt, w_mem_wr_nxt;
   logic [ADDR_WIDTH-1:0]    w_mem_addr_nxt;
   logic [L2_LINE_WIDTH-1:0] w_mem_wdata_nxt;
   logic                     w_unused_offset;

   function automatic logic [ENT_W-1:0] ent(input logic [SET_W-1:0] s, input logic [WAY_W-1:0] w);
      return {s, w};
   endfunction

   assign w_unused_offset = ^l1_addr[OFF_HI:OFF_LO];
   assign w_set = r_addr[IDX_HI:IDX_LO];
   assign w_tag = r_addr[TAG_HI:TAG_LO];

   l2_cache_lru u_lru (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_set        (w_set),
      .i_touch_en   (w_touch_en),
      .i_touch_way  (w_touch_way),
      .o_victim_way (w_lru_victim)
   );

   // Tag compare across the indexed set and lowest-numbered invalid way search
   always_comb begin
      w_hit       = 1'b0;
      w_hit_way   = '0;
      w_inv_found = 1'b0;
      w_inv_way   = '0;
      for (int w = L2_WAYS - 1; w >= 0; w--) begin
         if (r_valid[ent(w_set, WAY_W'(w))] && (r_tag[ent(w_set, WAY_W'(w))] == w_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_valid[ent(w_set, WAY_W'(w))]) begin
            w_inv_found = 1'b1;
            w_inv_way   = WAY_W'(w);
         end
      end
   end

   // Victim is chosen during LOOKUP and remembered for WRITEBACK / FETCH
   assign w_victim_new   = w_inv_found ? w_inv_way : w_lru_victim;
   assign w_cur_victim   = (r_state == S_LOOKUP) ? w_victim_new : r_victim;
   assign w_victim_dirty = r_valid[ent(w_set, w_victim_new)] && r_dirty[ent(w_set, w_victim_new)];

   assign w_lookup_hit = (r_state == S_LOOKUP) && w_hit;
   assign w_hit_wr     = w_lookup_hit && r_is_wr;
   assign w_wb_done    = (r_state == S_WRITEBACK) && mem_ready;
   assign w_fill       = (r_state == S_FETCH) && mem_ready;
   // Full-line write miss installs without a fetch, directly or after writeback
   assign w_install_wr = r_is_wr && (((r_state == S_LOOKUP) && !w_hit && !w_victim_dirty) || w_wb_done);

   assign w_arr_we    = w_hit_wr || w_install_wr || w_fill;
   assign w_arr_ent   = ent(w_set, w_hit_wr ? w_hit_way : w_cur_victim);
   assign w_arr_line  = w_fill ? mem_rdata : r_wdata;
   assign w_touch_en  = w_lookup_hit || w_install_wr || w_fill;
   assign w_touch_way = w_lookup_hit ? w_hit_way : w_cur_victim;

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:      if (l1_rd || l1_wr) w_next_state = S_LOOKUP;
         S_LOOKUP: begin
            if (w_hit)               w_next_state = S_RESPOND;
            else if (w_victim_dirty) w_next_state = S_WRITEBACK;
            else if (r_is_wr)        w_next_state = S_RESPOND;
            else                     w_next_state = S_FETCH;
         end
         S_WRITEBACK: if (mem_ready) w_next_state = r_is_wr ? S_RESPOND : S_FETCH;
         S_FETCH:     if (mem_ready) w_next_state = S_RESPOND;
         S_RESPOND:   w_next_state = S_IDLE;
         default:     w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs, computed for the cycle being entered and registered below
   always_comb begin
      w_l1_ready_nxt  = (r_state == S_RESPOND);
      w_mem_wr_nxt    = (w_next_state == S_WRITEBACK);
      w_mem_rd_nxt    = (w_next_state == S_FETCH);
      w_mem_addr_nxt  = '0;
      w_mem_wdata_nxt = '0;
      if (w_mem_wr_nxt) begin
         w_mem_addr_nxt  = line_addr(r_tag[ent(w_set, w_cur_victim)], w_set);
         w_mem_wdata_nxt = r_data[ent(w_set, w_cur_victim)];
      end else if (w_mem_rd_nxt) begin
         w_mem_addr_nxt  = line_addr(w_tag, w_set);
      end
   end

   // Registered port outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         l1_ready  <= 1'b0;
         mem_rd    <= 1'b0;
         mem_wr    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         l1_ready  <= w_l1_ready_nxt;
         mem_rd    <= w_mem_rd_nxt;
         mem_wr    <= w_mem_wr_nxt;
         mem_addr  <= w_mem_addr_nxt;
         mem_wdata <= w_mem_wdata_nxt;
      end
   end

   // Request latch, valid/dirty bookkeeping and the read-data register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_addr   <= '0;
         r_wdata  <= '0;
         r_is_wr  <= 1'b0;
         r_victim <= '0;
         r_valid  <= '0;
         r_dirty  <= '0;
         l1_rdata <= '0;
      end else begin
         if ((r_state == S_IDLE) && (l1_rd || l1_wr)) begin
            r_addr  <= l1_addr[ADDR_WIDTH-1:IDX_LO];
            r_wdata <= l1_wdata;
            r_is_wr <= l1_wr;
         end
         if (r_state == S_LOOKUP) r_victim <= w_victim_new;
         if (w_lookup_hit && !r_is_wr) l1_rdata <= r_data[ent(w_set, w_hit_way)];
         if (w_wb_done) r_dirty[ent(w_set, r_victim)] <= 1'b0;
         if (w_arr_we) begin
            r_valid[w_arr_ent] <= 1'b1;
            r_dirty[w_arr_ent] <= !w_fill;
         end
         if (w_fill) l1_rdata <= mem_rdata;
      end
   end

   // Line and tag storage; contents are qualified by the valid bits
   always_ff @(posedge clk) begin
      if (rst_n && w_arr_we) begin
         r_data[w_arr_ent] <= w_arr_line;
         r_tag[w_arr_ent]  <= w_tag;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_l2_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2_cache
// Purpose  : Self-checking bench for l2_cache: directed vector table, reset
//            abort sequence and randomized traffic against a recency-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2_cache;
   import l2_cache_pkg::*;

   typedef logic [L2_LINE_WIDTH-1:0] line_t;

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      line_t       wdata;
      bit          exp_rd;
      bit          exp_wr;
      logic [31:0] wb_addr;
      line_t       wb_data;
      line_t       rdata;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] l1_addr = '0;
   line_t       l1_wdata = '0;
   logic        l1_rd = 1'b0, l1_wr = 1'b0;
   line_t       l1_rdata;
   logic        l1_ready;
   logic [31:0] mem_addr;
   line_t       mem_wdata;
   logic        mem_rd, mem_wr;
   line_t       mem_rdata = '0;
   logic        mem_ready = 1'b0;

   always #5 clk = ~clk;

   l2_cache dut (
      .clk(clk), .rst_n(rst_n),
      .l1_addr(l1_addr), .l1_wdata(l1_wdata), .l1_rd(l1_rd), .l1_wr(l1_wr),
      .l1_rdata(l1_rdata), .l1_ready(l1_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   int checks = 0;
   int errors = 0;

   // Backing memory and cache model: per set, per way contents plus a recency
   // list of way numbers (index 0 = most recently used, index 7 = LRU)
   line_t       mem_store [logic [31:0]];
   bit          m_valid [L2_SETS][L2_WAYS];
   bit          m_dirty [L2_SETS][L2_WAYS];
   logic [19:0] m_tag   [L2_SETS][L2_WAYS];
   line_t       m_data  [L2_SETS][L2_WAYS];
   int          m_order [L2_SETS][L2_WAYS];
   line_t       m_last_rdata;

   task automatic chk(input bit ok, input string name, input string act, input string req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %s, expected %s", name, act, req);
      end
   endtask

   function automatic line_t mem_line(input logic [31:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return {16{a ^ 32'h5A5A_F00F}};
   endfunction

   task automatic model_reset();
      for (int s = 0; s < L2_SETS; s++) begin
         for (int w = 0; w < L2_WAYS; w++) begin
            m_valid[s][w] = 1'b0;
            m_dirty[s][w] = 1'b0;
            m_order[s][w] = w;
         end
      end
      m_last_rdata = '0;
   endtask

   task automatic model_touch(input int s, input int w);
      int p;
      p = 0;
      for (int i = 0; i < L2_WAYS; i++) if (m_order[s][i] == w) p = i;
      for (int i = p; i > 0; i--) m_order[s][i] = m_order[s][i-1];
      m_order[s][0] = w;
   endtask

   task automatic model_predict(input bit wr, input logic [31:0] addr, input line_t wdata,
                                output bit exp_rd, output bit exp_wr, output logic [31:0] wb_addr,
                                output line_t wb_data, output line_t exp_rdata);
      int s, w, v;
      logic [19:0] t;
      s = int'(addr[11:6]);
      t = addr[31:12];
      w = -1;
      v = -1;
      exp_rd = 1'b0; exp_wr = 1'b0; wb_addr = '0; wb_data = '0;
      for (int i = 0; i < L2_WAYS; i++) if (m_valid[s][i] && m_tag[s][i] == t) w = i;
      if (w >= 0) begin
         if (wr) begin
            m_data[s][w]  = wdata;
            m_dirty[s][w] = 1'b1;
         end else begin
            m_last_rdata = m_data[s][w];
         end
         model_touch(s, w);
      end else begin
         for (int i = L2_WAYS - 1; i >= 0; i--) if (!m_valid[s][i]) v = i;
         if (v < 0) v = m_order[s][L2_WAYS-1];
         if (m_valid[s][v] && m_dirty[s][v]) begin
            exp_wr  = 1'b1;
            wb_addr = {m_tag[s][v], addr[11:6], 6'b0};
            wb_data = m_data[s][v];
            mem_store[wb_addr] = wb_data;
         end
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = t;
         if (wr) begin
            m_data[s][v]  = wdata;
            m_dirty[s][v] = 1'b1;
         end else begin
            exp_rd        = 1'b1;
            m_data[s][v]  = mem_line({addr[31:6], 6'b0});
            m_dirty[s][v] = 1'b0;
            m_last_rdata  = m_data[s][v];
         end
         model_touch(s, v);
      end
      exp_rdata = m_last_rdata;
   endtask

   // Issue one request at a negedge, service the memory side, check the result.
   // Returns at a negedge, one cycle after the l1_ready pulse.
   task automatic do_op(input bit wr, input bit both, input logic [31:0] addr, input line_t wdata,
                        input bit exp_rd, input bit exp_wr, input logic [31:0] wb_addr,
                        input line_t wb_data, input line_t exp_rdata, input string nm);
      int    n, ready_n, memrdy_n, rd_cnt, wr_cnt, delay;
      bit    prev_rd, prev_wr, done;
      line_t got;
      l1_addr  = addr;
      l1_wdata = wdata;
      l1_wr    = wr;
      l1_rd    = !wr || both;
      @(negedge clk);
      l1_rd = 1'b0; l1_wr = 1'b0; l1_addr = $urandom;
      n = 1; ready_n = 0; memrdy_n = -100; rd_cnt = 0; wr_cnt = 0; delay = 0;
      prev_rd = 1'b0; prev_wr = 1'b0; done = 1'b0; got = '0;
      while (!done && n < 200) begin
         if (mem_rd && mem_wr) chk(1'b0, {nm, "_rd_wr_overlap"}, "both high", "exclusive");
         if (mem_wr && !prev_wr) begin
            wr_cnt++;
            chk(mem_addr == wb_addr, {nm, "_wb_addr"}, $sformatf("%h", mem_addr), $sformatf("%h", wb_addr));
            chk(mem_wdata == wb_data, {nm, "_wb_data"}, $sformatf("%h", mem_wdata), $sformatf("%h", wb_data));
            delay = $urandom_range(0, 3);
         end
         if (mem_rd && !prev_rd) begin
            rd_cnt++;
            chk(mem_addr == {addr[31:6], 6'b0}, {nm, "_fetch_addr"}, $sformatf("%h", mem_addr),
                $sformatf("%h", {addr[31:6], 6'b0}));
            delay = $urandom_range(0, 3);
         end
         prev_wr = mem_wr;
         prev_rd = mem_rd;
         if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_rd || mem_wr) begin
            if (delay == 0) begin
               mem_ready = 1'b1;
               memrdy_n  = n;
               mem_rdata = mem_rd ? mem_line(mem_addr) : {16{$urandom}};
            end else begin
               delay--;
            end
         end
         if (l1_ready) begin
            ready_n = n;
            got     = l1_rdata;
            done    = 1'b1;
         end else begin
            @(negedge clk);
            n++;
         end
      end
      mem_ready = 1'b0;
      chk(done, {nm, "_ready"}, done ? "pulse" : "timeout", "pulse");
      chk(rd_cnt == int'(exp_rd), {nm, "_fetch_count"}, $sformatf("%0d", rd_cnt), $sformatf("%0d", exp_rd));
      chk(wr_cnt == int'(exp_wr), {nm, "_wb_count"}, $sformatf("%0d", wr_cnt), $sformatf("%0d", exp_wr));
      if (done) begin
         if (!exp_rd && !exp_wr)
            chk(ready_n == 3, {nm, "_latency"}, $sformatf("%0d", ready_n), "3");
         else
            chk(ready_n - memrdy_n == 2, {nm, "_miss_latency"}, $sformatf("%0d", ready_n - memrdy_n), "2");
         chk(got == exp_rdata, {nm, "_rdata"}, $sformatf("%h", got), $sformatf("%h", exp_rdata));
      end
      @(negedge clk);
      chk(!l1_ready, {nm, "_ready_width"}, $sformatf("%0b", l1_ready), "0");
   endtask

   vec_t  vecs [13];
   line_t c_dead, c_cafe, c_face;

   initial begin
      bit          e_rd, e_wr;
      logic [31:0] e_wba;
      line_t       e_wbd, e_rdata;
      int          n;

      c_dead = {8{64'hDEADBEEFCAFEBABE}};
      c_cafe = {8{64'hCAFEBABECAFEBABE}};
      c_face = {8{64'hFACEFACEFACEFACE}};
      mem_store[32'h0000_1000] = c_dead;

      // Directed vectors from reset, expectations worked out by hand
      vecs[0] = '{1'b0, 32'h1000, '0, 1'b1, 1'b0, 32'h0, '0, c_dead};
      vecs[1] = '{1'b0, 32'h1000, '0, 1'b0, 1'b0, 32'h0, '0, c_dead};
      vecs[2] = '{1'b1, 32'h1000, c_cafe, 1'b0, 1'b0, 32'h0, '0, c_dead};
      vecs[3] = '{1'b0, 32'h1000, '0, 1'b0, 1'b0, 32'h0, '0, c_cafe};
      for (int k = 0; k < 7; k++) begin
         vecs[4+k] = '{1'b1, 32'(32'h2000 + k * 32'h1000), {16{32'h1000_0000 + 32'(k)}},
                       1'b0, 1'b0, 32'h0, '0, c_cafe};
      end
      vecs[11] = '{1'b1, 32'h9000, c_face, 1'b0, 1'b1, 32'h1000, c_cafe, c_cafe};
      vecs[12] = '{1'b0, 32'h1000, '0, 1'b1, 1'b1, 32'h2000, {16{32'h1000_0000}}, c_cafe};

      // Reset state
      model_reset();
      repeat (3) @(negedge clk);
      chk(l1_ready == 1'b0, "rst_l1_ready", $sformatf("%0b", l1_ready), "0");
      chk(mem_rd == 1'b0 && mem_wr == 1'b0, "rst_mem_req", $sformatf("%0b%0b", mem_rd, mem_wr), "00");
      chk(mem_addr == '0, "rst_mem_addr", $sformatf("%h", mem_addr), "0");
      chk(l1_rdata == '0, "rst_l1_rdata", $sformatf("%h", l1_rdata), "0");
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) begin
         model_predict(vecs[i].wr, vecs[i].addr, vecs[i].wdata, e_rd, e_wr, e_wba, e_wbd, e_rdata);
         do_op(vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_wr,
               vecs[i].wb_addr, vecs[i].wb_data, vecs[i].rdata, $sformatf("vec%0d", i));
      end

      // Reset while a fetch is outstanding
      l1_addr = 32'h0000_0040; l1_rd = 1'b1;
      @(negedge clk);
      l1_rd = 1'b0;
      n = 0;
      while (!mem_rd && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk(mem_rd == 1'b1, "abort_fetch_started", $sformatf("%0b", mem_rd), "1");
      rst_n = 1'b0;
      @(negedge clk);
      chk(mem_rd == 1'b0, "abort_mem_rd_drop", $sformatf("%0b", mem_rd), "0");
      chk(l1_ready == 1'b0, "abort_no_ready", $sformatf("%0b", l1_ready), "0");
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
      model_predict(1'b0, 32'h1000, '0, e_rd, e_wr, e_wba, e_wbd, e_rdata);
      do_op(1'b0, 1'b0, 32'h1000, '0, e_rd, e_wr, e_wba, e_wbd, e_rdata, "post_reset_miss");

      // Randomized traffic over a few sets with more tags than ways
      for (int i = 0; i < 250; i++) begin
         bit          wr, both;
         logic [31:0] a;
         line_t       d;
         wr   = ($urandom_range(0, 1) == 1);
         both = wr && ($urandom_range(0, 3) == 0);
         a    = (32'($urandom_range(0, 11)) << 12) | (32'($urandom_range(0, 3)) << 6) | 32'($urandom_range(0, 63));
         d    = {16{$urandom}};
         model_predict(wr, a, d, e_rd, e_wr, e_wba, e_wbd, e_rdata);
         do_op(wr, both, a, d, e_rd, e_wr, e_wba, e_wbd, e_rdata, $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
